// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result stage: NZCV bit positions, skid state
// encoding and the width-independent part of a buffered entry.
package alu_pkg;

    localparam int NZCV_N = 3;
    localparam int NZCV_Z = 2;
    localparam int NZCV_C = 1;
    localparam int NZCV_V = 0;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_t;

    // Packages cannot take parameters, so the WIDTH-dependent data field is
    // prepended by the module that owns WIDTH; everything else lives here.
    typedef struct packed {
        logic [3:0] nzcv;
        logic       sel_err;
        logic       set_flags;
    } entry_meta_t;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational N/Z flag derivation for one result word.
module alu_flag_gen #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_data,
    output logic             o_n,
    output logic             o_z
);

    assign o_n = i_data[WIDTH-1];
    assign o_z = (i_data == '0);

endmodule

// File: rtl/alu_result_stage.sv
// ALU result select stage: picks one of NUM_OPS channel results, derives NZCV,
// and buffers it in a 2-entry skid so in_ready is a registered signal.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int NUM_OPS = 9,
    parameter int SEL_W   = $clog2(NUM_OPS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SEL_W-1:0]         sel,
    input  logic [NUM_OPS*WIDTH-1:0] results,
    input  logic [NUM_OPS-1:0]       carry_vec,
    input  logic [NUM_OPS-1:0]       ovf_vec,
    input  logic                     set_flags,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [3:0]               out_nzcv,
    output logic                     out_sel_err,
    output logic [3:0]               flags_q
);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        entry_meta_t      meta;
    } entry_t;

    skid_state_t      r_state;
    skid_state_t      w_state_nxt;
    entry_t           r_main;
    entry_t           r_skid;
    entry_t           w_new;
    logic [3:0]       r_flags;
    logic             r_in_ready;
    logic             w_accept;
    logic             w_emit;
    logic             w_sel_err;
    logic [WIDTH-1:0] w_data;
    logic             w_c;
    logic             w_v;
    logic             w_n;
    logic             w_z;

    // Out-of-range selects fall back to channel 0 and are tagged.
    always_comb begin
        w_sel_err = (32'(sel) >= NUM_OPS);
        w_data    = results[WIDTH-1:0];
        w_c       = carry_vec[0];
        w_v       = ovf_vec[0];
        for (int k = 1; k < NUM_OPS; k++) begin
            if (!w_sel_err && sel == SEL_W'(k)) begin
                w_data = results[k*WIDTH +: WIDTH];
                w_c    = carry_vec[k];
                w_v    = ovf_vec[k];
            end
        end
    end

    alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
        .i_data (w_data),
        .o_n    (w_n),
        .o_z    (w_z)
    );

    always_comb begin
        w_new                   = '0;
        w_new.data              = w_data;
        w_new.meta.nzcv[NZCV_N] = w_n;
        w_new.meta.nzcv[NZCV_Z] = w_z;
        w_new.meta.nzcv[NZCV_C] = w_c;
        w_new.meta.nzcv[NZCV_V] = w_v;
        w_new.meta.sel_err      = w_sel_err;
        w_new.meta.set_flags    = set_flags;
    end

    assign in_ready = r_in_ready && rst_n;
    assign w_accept = in_valid && in_ready;
    assign w_emit   = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_EMPTY;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: if (w_accept) w_state_nxt = ST_ONE;
            ST_ONE: begin
                if (w_accept && !w_emit)      w_state_nxt = ST_FULL;
                else if (w_emit && !w_accept) w_state_nxt = ST_EMPTY;
            end
            ST_FULL:  if (w_emit) w_state_nxt = ST_ONE;
            default:  w_state_nxt = ST_EMPTY;
        endcase
    end

    always_comb begin
        out_valid = (r_state != ST_EMPTY);
    end

    // in_ready is registered from the next state so it never depends on inputs.
    always_ff @(posedge clk) begin
        if (!rst_n) r_in_ready <= 1'b1;
        else        r_in_ready <= (w_state_nxt != ST_FULL);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_main  <= '0;
            r_skid  <= '0;
            r_flags <= '0;
        end else begin
            if (w_emit && r_main.meta.set_flags) r_flags <= r_main.meta.nzcv;
            case (r_state)
                ST_EMPTY: if (w_accept) r_main <= w_new;
                ST_ONE: begin
                    if (w_accept && w_emit) r_main <= w_new;
                    else if (w_accept)      r_skid <= w_new;
                end
                ST_FULL:  if (w_emit) r_main <= r_skid;
                default: ;
            endcase
        end
    end

    assign out_data    = r_main.data;
    assign out_nzcv    = r_main.meta.nzcv;
    assign out_sel_err = r_main.meta.sel_err;
    assign flags_q     = r_flags;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed self-checking bench for alu_result_stage (32x9 instance plus an 8x2 instance).
module tb_alu_result_stage;

    localparam int W = 32;
    localparam int N = 9;
    localparam int S = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid, in_ready, set_flags, out_valid, out_ready, out_sel_err;
    logic [S-1:0]   sel;
    logic [N*W-1:0] results;
    logic [N-1:0]   carry_vec, ovf_vec;
    logic [W-1:0]   out_data;
    logic [3:0]     out_nzcv, flags_q;

    logic        in_valid2, in_ready2, set_flags2, out_valid2, out_ready2, out_sel_err2;
    logic [0:0]  sel2;
    logic [15:0] results2;
    logic [1:0]  carry2, ovf2;
    logic [7:0]  out_data2;
    logic [3:0]  out_nzcv2, flags_q2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_result_stage #(.WIDTH(W), .NUM_OPS(N)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .sel(sel), .results(results), .carry_vec(carry_vec), .ovf_vec(ovf_vec),
        .set_flags(set_flags), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_nzcv(out_nzcv), .out_sel_err(out_sel_err),
        .flags_q(flags_q)
    );

    alu_result_stage #(.WIDTH(8), .NUM_OPS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .sel(sel2), .results(results2), .carry_vec(carry2), .ovf_vec(ovf2),
        .set_flags(set_flags2), .out_valid(out_valid2), .out_ready(out_ready2),
        .out_data(out_data2), .out_nzcv(out_nzcv2), .out_sel_err(out_sel_err2),
        .flags_q(flags_q2)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int ch, input logic [W-1:0] d);
        results[ch*W +: W] = d;
    endtask

    logic [W-1:0] sd;
    logic         sc, sv, ssf;
    logic [3:0]   exp_flags;
    logic [3:0]   prev_nzcv;
    logic         prev_sf;

    initial begin
        rst_n = 1'b0; in_valid = 0; sel = '0; results = '0; carry_vec = '0; ovf_vec = '0;
        set_flags = 0; out_ready = 0;
        in_valid2 = 0; sel2 = '0; results2 = '0; carry2 = '0; ovf2 = '0; set_flags2 = 0; out_ready2 = 0;
        tick(); tick();
        chk("rst_in_ready_low", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_nzcv", out_nzcv, 0);
        chk("rst_flags_q", flags_q, 0);
        rst_n = 1'b1;
        #1;
        chk("rst_release_in_ready", in_ready, 1);

        // negative result with carry, flags committed on emit
        sel = 4'd4; put(4, 32'h8000_0000); carry_vec[4] = 1'b1; set_flags = 1; out_ready = 1; in_valid = 1;
        tick();
        in_valid = 0;
        chk("t1_out_valid", out_valid, 1);
        chk("t1_out_data", out_data, 32'h8000_0000);
        chk("t1_out_nzcv", out_nzcv, 4'b1010);
        chk("t1_sel_err", out_sel_err, 0);
        chk("t1_flags_before_emit", flags_q, 0);
        tick();
        chk("t1_flags_after_emit", flags_q, 4'b1010);
        chk("t1_empty", out_valid, 0);

        // out-of-range select falls back to channel 0, held while stalled
        carry_vec = '0; put(0, 32'h0); sel = 4'd12; set_flags = 0; out_ready = 0; in_valid = 1;
        tick();
        in_valid = 0;
        chk("t2_out_data", out_data, 0);
        chk("t2_out_nzcv", out_nzcv, 4'b0100);
        chk("t2_sel_err", out_sel_err, 1);
        tick();
        chk("t2_hold_valid", out_valid, 1);
        chk("t2_hold_nzcv", out_nzcv, 4'b0100);
        chk("t2_hold_sel_err", out_sel_err, 1);
        out_ready = 1;
        tick();
        chk("t2_flags_unchanged", flags_q, 4'b1010);
        chk("t2_empty", out_valid, 0);

        // three back-to-back accepts against a stalled sink
        out_ready = 0;
        put(1, 32'hAAAA_0001); put(2, 32'hBBBB_0002); put(3, 32'hCCCC_0003);
        in_valid = 1; sel = 4'd1; tick();
        sel = 4'd2; tick();
        chk("t3_full_in_ready", in_ready, 0);
        sel = 4'd3; tick();
        in_valid = 0;
        chk("t3_A_data", out_data, 32'hAAAA_0001);
        chk("t3_A_nzcv", out_nzcv, 4'b1000);
        out_ready = 1; tick();
        chk("t3_B_data", out_data, 32'hBBBB_0002);
        chk("t3_B_valid", out_valid, 1);
        chk("t3_one_in_ready", in_ready, 1);
        tick();
        chk("t3_empty_no_C", out_valid, 0);

        // 16-entry stream at full rate
        exp_flags = 4'b1010; prev_nzcv = '0; prev_sf = 0;
        for (int i = 0; i < 16; i++) begin
            sd = W'(i) << 28; sc = i[0]; sv = i[1]; ssf = (i % 3 == 0);
            sel = S'(i % 9); put(i % 9, sd);
            carry_vec = '0; carry_vec[i % 9] = sc;
            ovf_vec = '0; ovf_vec[i % 9] = sv;
            set_flags = ssf; in_valid = 1;
            if (i > 0 && prev_sf) exp_flags = prev_nzcv;
            tick();
            chk("t4_valid", out_valid, 1);
            chk("t4_data", out_data, sd);
            chk("t4_nzcv", out_nzcv, {sd[W-1], sd == 0, sc, sv});
            chk("t4_in_ready", in_ready, 1);
            chk("t4_flags", flags_q, exp_flags);
            prev_nzcv = {sd[W-1], sd == 0, sc, sv}; prev_sf = ssf;
        end
        in_valid = 0;
        if (prev_sf) exp_flags = prev_nzcv;
        tick();
        chk("t4_drained", out_valid, 0);
        chk("t4_final_flags", flags_q, exp_flags);

        // reset while full with an emit pending
        out_ready = 0; sel = 4'd4; put(4, 32'h8000_0000);
        carry_vec = '0; carry_vec[4] = 1'b1; ovf_vec = '0; set_flags = 1; in_valid = 1;
        tick(); tick();
        in_valid = 0;
        chk("t5_full", in_ready, 0);
        out_ready = 1; rst_n = 0;
        tick();
        chk("t5_in_ready_during_rst", in_ready, 0);
        rst_n = 1;
        #1;
        chk("t5_out_valid", out_valid, 0);
        chk("t5_flags_q", flags_q, 0);
        chk("t5_in_ready", in_ready, 1);
        chk("t5_out_data", out_data, 0);
        tick();
        chk("t5_stays_empty", out_valid, 0);

        // narrow build: zero result with overflow on channel 1
        sel2 = 1'b1; results2 = 16'h0000; ovf2 = 2'b10; carry2 = 2'b00; out_ready2 = 1; in_valid2 = 1;
        tick();
        in_valid2 = 0;
        chk("t6_valid", out_valid2, 1);
        chk("t6_data", out_data2, 8'h00);
        chk("t6_nzcv", out_nzcv2, 4'b0101);
        chk("t6_sel_err", out_sel_err2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
